// File: rtl/matrix_pkg.sv
// Shared definitions for the HUB75 matrix scan controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matrix_pkg;

  // Scan sequencer states: shift a row out, latch it, then show it for one bit plane.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  // Default panel geometry and brightness timing (64x32 panel, 1/16 scan).
  localparam int DEF_COLS    = 64;
  localparam int DEF_ROWS    = 16;
  localparam int DEF_PLANES  = 4;
  localparam int DEF_BASE_ON = 8;

  // Frame-buffer address {buf_sel, row, col} for the default geometry.
  localparam int ADDR_W = 1 + $clog2(DEF_ROWS) + $clog2(DEF_COLS);

  // Channel positions inside the pixel word {r0,g0,b0,r1,g1,b1}, counted in
  // PLANES-bit fields from the LSB.
  localparam int CH_R0 = 5;
  localparam int CH_G0 = 4;
  localparam int CH_B0 = 3;
  localparam int CH_R1 = 2;
  localparam int CH_G1 = 1;
  localparam int CH_B1 = 0;

endpackage

// File: rtl/matrix_show_timer.sv
// Loadable down-counter timing the OE-enabled window of one bit plane.
// Latency: done is asserted combinationally during the last counted cycle.
// Backpressure: none; counts every cycle dec is high.
module matrix_show_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  // Reload at LATCH, then count down once per SHOW cycle, parking at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // A window of N cycles sees cnt = N..1; the cycle holding 1 is the last one.
  assign done = dec && (cnt == W'(1));

endmodule

// File: rtl/matrix_scan_ctrl.sv
// HUB75 scan controller: streams double-buffered pixel data as BCM bit planes.
// Latency: rd_data consumed 1 clk after rd_addr; each plane takes 2*COLS+3+(BASE_ON<<p) clks.
// Backpressure: none; the frame buffer must answer every read in exactly one clock.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int  COLS    = DEF_COLS,
  parameter int  ROWS    = DEF_ROWS,
  parameter int  PLANES  = DEF_PLANES,
  parameter int  BASE_ON = DEF_BASE_ON,
  localparam int COL_W   = $clog2(COLS),
  localparam int ROW_W   = $clog2(ROWS),
  localparam int AW      = 1 + ROW_W + COL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [AW-1:0]         rd_addr,
  input  logic [6*PLANES-1:0]   rd_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  buf_sel,
  output logic                  frame_start,
  output logic                  A,
  output logic                  B,
  output logic                  C,
  output logic                  D,
  output logic                  R0,
  output logic                  G0,
  output logic                  B0,
  output logic                  R1,
  output logic                  G1,
  output logic                  B1,
  output logic                  SCLK,
  output logic                  OE,
  output logic                  LAT
);

  // SHIFT phase counter runs 0 .. 2*COLS+1; even steps issue reads, odd steps capture data.
  localparam int K_W    = $clog2(2 * COLS + 2);
  localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int SHOW_W = $clog2((BASE_ON << (PLANES - 1)) + 1);

  localparam logic [K_W-1:0]   K_LAST     = K_W'(2 * COLS + 1);
  localparam logic [K_W-1:0]   K_RD_END   = K_W'(2 * COLS);
  localparam logic [K_W-1:0]   K_SCLK_1ST = K_W'(3);
  localparam logic [PL_W-1:0]  PL_LAST    = PL_W'(PLANES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    k_nxt;
  logic [PL_W-1:0]   plane;
  logic [PL_W-1:0]   plane_nxt;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  row_nxt;
  logic              buf_nxt;
  logic              ack_nxt;

  logic              last_plane;
  logic              last_row;
  logic              rd_issue;
  logic              rgb_capture;
  logic              entering_shift;

  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_done;
  logic [SHOW_W-1:0] tmr_val;

  logic [PLANES-1:0] ch_r0;
  logic [PLANES-1:0] ch_g0;
  logic [PLANES-1:0] ch_b0;
  logic [PLANES-1:0] ch_r1;
  logic [PLANES-1:0] ch_g1;
  logic [PLANES-1:0] ch_b1;

  // Split the pixel word into its six colour channels.
  assign ch_r0 = rd_data[CH_R0*PLANES +: PLANES];
  assign ch_g0 = rd_data[CH_G0*PLANES +: PLANES];
  assign ch_b0 = rd_data[CH_B0*PLANES +: PLANES];
  assign ch_r1 = rd_data[CH_R1*PLANES +: PLANES];
  assign ch_g1 = rd_data[CH_G1*PLANES +: PLANES];
  assign ch_b1 = rd_data[CH_B1*PLANES +: PLANES];

  assign last_plane = (plane == PL_LAST);
  assign last_row   = (row == ROW_LAST);

  // Plane p is shown for BASE_ON<<p clocks, giving binary-weighted brightness.
  assign tmr_val = SHOW_W'(BASE_ON) << plane;

  matrix_show_timer #(
    .W(SHOW_W)
  ) u_show_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  // Sequencer state and scan position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      plane   <= '0;
      row     <= '0;
      buf_sel <= 1'b0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      plane   <= plane_nxt;
      row     <= row_nxt;
      buf_sel <= buf_nxt;
    end
  end

  // Next-state, scan-position stepping and frame-end buffer swap.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    plane_nxt = plane;
    row_nxt   = row;
    buf_nxt   = buf_sel;
    ack_nxt   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (k == K_LAST) begin
          state_nxt = ST_LATCH;
          k_nxt     = '0;
        end else begin
          k_nxt = k + K_W'(1);
        end
      end
      ST_LATCH: begin
        tmr_load  = 1'b1;
        state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          if (!last_plane) begin
            plane_nxt = plane + PL_W'(1);
            state_nxt = ST_SHIFT;
          end else begin
            plane_nxt = '0;
            if (!last_row) begin
              row_nxt   = row + ROW_W'(1);
              state_nxt = ST_SHIFT;
            end else begin
              // Frame end: the only point where the front buffer may change.
              row_nxt = '0;
              if (swap_req) begin
                buf_nxt = ~buf_sel;
                ack_nxt = 1'b1;
              end
              state_nxt = en ? ST_SHIFT : ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reads go out on even SHIFT steps; data arriving on the following odd step is captured.
  assign rd_issue       = (state_nxt == ST_SHIFT) && !k_nxt[0] && (k_nxt < K_RD_END);
  assign rgb_capture    = (state == ST_SHIFT) && k[0] && (k < K_RD_END);
  assign entering_shift = (state_nxt == ST_SHIFT) && (state != ST_SHIFT);

  // Pin-side registers, all decoded from next-state so the pins change glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr      <= '0;
      {D, C, B, A} <= 4'd0;
      {R0, G0, B0} <= 3'd0;
      {R1, G1, B1} <= 3'd0;
      SCLK         <= 1'b0;
      OE           <= 1'b1;
      LAT          <= 1'b0;
      swap_ack     <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      // SCLK pulses one step after each capture, so data has a full cycle of setup.
      SCLK        <= (state_nxt == ST_SHIFT) && k_nxt[0] && (k_nxt >= K_SCLK_1ST);
      OE          <= (state_nxt != ST_SHOW);
      LAT         <= (state_nxt == ST_LATCH);
      swap_ack    <= ack_nxt;
      frame_start <= entering_shift && (row_nxt == '0) && (plane_nxt == '0);
      if (rd_issue) begin
        rd_addr <= {buf_nxt, row_nxt, k_nxt[COL_W:1]};
      end
      if (rgb_capture) begin
        {R0, G0, B0} <= {ch_r0[plane], ch_g0[plane], ch_b0[plane]};
        {R1, G1, B1} <= {ch_r1[plane], ch_g1[plane], ch_b1[plane]};
      end
      // Row address only moves as LATCH begins, while the panel is still blanked.
      if ((state == ST_SHIFT) && (state_nxt == ST_LATCH)) begin
        {D, C, B, A} <= 4'(row);
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: expected line/frame/swap events are
// queued by the stimulus and consumed by an independent pin-level monitor.
module tb_matrix_scan_ctrl;
  import matrix_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              swap_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic              swap_ack, buf_sel, frame_start;
  logic              A, B, C, D, R0, G0, B0, R1, G1, B1, SCLK, OE, LAT;

  logic [23:0]       mem [2**ADDR_W];

  always #5 clk = ~clk;

  // Synchronous frame-buffer RAM: one clock read latency.
  always @(posedge clk) rd_data <= mem[rd_addr];

  matrix_scan_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel),
    .frame_start(frame_start), .A(A), .B(B), .C(C), .D(D),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .SCLK(SCLK), .OE(OE), .LAT(LAT)
  );

  typedef struct {
    int row;
    int first_sclk;
    int sclk_cnt;
    int lat_t;
    int oe_len;
    int nz_cnt;
    int nz_or;
    int nz_idx;
  } line_rec_t;

  line_rec_t line_q[$];
  int        fs_q[$];
  int        swap_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  int        oe_len_tbl[4] = '{8, 16, 32, 64};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue the expected per-line records of a frame read from buffer b, rows 0..nrows-1.
  // Buffer 1 is all ones; buffer 0 holds a single r0 bit2 pixel at row 3 col 5.
  task automatic push_frame(input int b, input int nrows);
    line_rec_t e;
    fs_q.push_back(b);
    for (int r = 0; r < nrows; r++) begin
      for (int p = 0; p < 4; p++) begin
        e.row = r; e.first_sclk = 3; e.sclk_cnt = 64; e.lat_t = 130;
        e.oe_len = oe_len_tbl[p];
        if (b == 1) begin
          e.nz_cnt = 64; e.nz_or = 'h3f; e.nz_idx = 64;
        end else if (r == 3 && p == 2) begin
          e.nz_cnt = 1; e.nz_or = 'h20; e.nz_idx = 6;
        end else begin
          e.nz_cnt = 0; e.nz_or = 0; e.nz_idx = 0;
        end
        line_q.push_back(e);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rd_addr"}, int'(rd_addr), 0);
    check({tag, " row DCBA"}, int'({D, C, B, A}), 0);
    check({tag, " rgb"}, int'({R0, G0, B0, R1, G1, B1}), 0);
    check({tag, " SCLK"}, int'(SCLK), 0);
    check({tag, " OE"}, int'(OE), 1);
    check({tag, " LAT"}, int'(LAT), 0);
    check({tag, " swap_ack"}, int'(swap_ack), 0);
    check({tag, " frame_start"}, int'(frame_start), 0);
    check({tag, " buf_sel"}, int'(buf_sel), 0);
  endtask

  task automatic wait_lines(input int budget, input string what);
    int n = 0;
    while (line_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({what, " lines outstanding"}, line_q.size(), 0);
  endtask

  // Monitor state.
  bit         line_on = 0;
  int         line_t, first_sclk, sclk_cnt, lat_t, lat_row, oe_len, nz_cnt, nz_or, nz_idx;
  int         line_no = 0;
  int         last_fs = 0;
  logic       oe_prev = 1'b1;
  logic       sclk_prev = 1'b0;
  logic [3:0] abcd_prev = 4'd0;

  // Monitor: continuous pin rules plus scoreboard pops on each completed event.
  always @(negedge clk) begin
    logic [5:0] rgb;
    logic [3:0] abcd;
    line_rec_t  e;
    int         b;
    cyc++;
    rgb  = {R0, G0, B0, R1, G1, B1};
    abcd = {D, C, B, A};
    if (rst) begin
      line_on   = 0;
      oe_prev   = 1'b1;
      sclk_prev = 1'b0;
    end else begin
      if (!OE && !oe_prev) check("row stable while OE low", int'(abcd), int'(abcd_prev));
      if (LAT) check("OE high during LAT", int'(OE), 1);
      if (SCLK) check("OE high during SCLK", int'(OE), 1);

      if (swap_ack) begin
        if (swap_q.size() == 0) begin
          check("swap_ack unexpected", int'(swap_ack), 0);
        end else begin
          b = swap_q.pop_front();
          check("buf_sel after swap", int'(buf_sel), b);
          check("swap_ack with frame_start", int'(frame_start), 1);
          check("swap_ack cycles from frame_start", cyc - last_fs, 10304);
        end
      end

      if (frame_start) begin
        if (fs_q.size() == 0) begin
          check("frame_start unexpected", int'(frame_start), 0);
        end else begin
          b = fs_q.pop_front();
          check("frame_start buf_sel", int'(buf_sel), b);
          check("frame_start rd_addr", int'(rd_addr), b << 10);
        end
        last_fs = cyc;
      end

      if (OE && !oe_prev && line_on) begin
        if (line_q.size() == 0) begin
          check("line unexpected oe_len", oe_len, 0);
        end else begin
          e = line_q.pop_front();
          check($sformatf("line %0d row", line_no), lat_row, e.row);
          check($sformatf("line %0d first SCLK", line_no), first_sclk, e.first_sclk);
          check($sformatf("line %0d SCLK count", line_no), sclk_cnt, e.sclk_cnt);
          check($sformatf("line %0d LAT pos", line_no), lat_t, e.lat_t);
          check($sformatf("line %0d OE low len", line_no), oe_len, e.oe_len);
          check($sformatf("line %0d rgb nz count", line_no), nz_cnt, e.nz_cnt);
          check($sformatf("line %0d rgb nz bits", line_no), nz_or, e.nz_or);
          check($sformatf("line %0d rgb nz index", line_no), nz_idx, e.nz_idx);
        end
        line_no++;
        line_on = 0;
      end

      if (frame_start || (OE && !oe_prev)) begin
        line_on = 1; line_t = 0; first_sclk = -1; sclk_cnt = 0; lat_t = -1;
        lat_row = -1; oe_len = 0; nz_cnt = 0; nz_or = 0; nz_idx = 0;
      end else if (line_on) begin
        line_t++;
      end

      if (line_on) begin
        if (SCLK && !sclk_prev) begin
          sclk_cnt++;
          if (sclk_cnt == 1) first_sclk = line_t;
          if (rgb != 6'd0) begin
            nz_cnt++;
            nz_or  = nz_or | int'(rgb);
            nz_idx = sclk_cnt;
          end
        end
        if (LAT) begin
          lat_t   = line_t;
          lat_row = int'(abcd);
        end
        if (!OE) oe_len++;
      end
      oe_prev   = OE;
      sclk_prev = SCLK;
      abcd_prev = abcd;
    end
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; swap_req = 1'b0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = (i >= 1024) ? 24'hFFFFFF : 24'h000000;
    mem[197] = 24'h400000;   // buffer 0, row 3, col 5: r0 bit 2

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle OE", int'(OE), 1);
    check("idle SCLK", int'(SCLK), 0);

    // Frame 1 from buffer 0 with a mid-frame swap request; frame 2 from buffer 1.
    push_frame(0, 16);
    push_frame(1, 16);
    swap_q.push_back(1);
    en = 1'b1;
    repeat (3000) @(negedge clk);
    swap_req = 1'b1;
    n = 0;
    while (!swap_ack && n < 12000) begin
      @(negedge clk);
      n++;
    end
    check("swap_ack seen", int'(swap_ack), 1);
    swap_req = 1'b0;

    // Drop en mid-frame 2: the frame must run to completion, then idle.
    repeat (4000) @(negedge clk);
    en = 1'b0;
    wait_lines(12000, "frame2");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post-frame idle OE", int'(OE), 1);
      check("post-frame idle SCLK", int'(SCLK), 0);
      check("post-frame idle buf_sel", int'(buf_sel), 1);
    end

    // Frame 3 from buffer 1, aborted by reset during SHOW of row 7 with a swap pending.
    push_frame(1, 7);
    en = 1'b1;
    n = 0;
    while (!(LAT && {D, C, B, A} == 4'd7) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("row 7 LAT seen", int'({D, C, B, A}), 7);
    check("frame3 lines before row 7", line_q.size(), 0);
    swap_req = 1'b1;
    repeat (3) @(negedge clk);
    check("OE low before reset", int'(OE), 0);
    #2;
    rst = 1'b1;
    swap_req = 1'b0;
    #1;
    check_reset_outputs("async reset");

    // Frame 4 restarts at row 0 plane 0 from buffer 0; no swap may occur.
    push_frame(0, 16);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    en = 1'b0;
    wait_lines(12000, "frame4");
    repeat (20) @(negedge clk);
    check("swap events outstanding", swap_q.size(), 0);
    check("frame_start events outstanding", fs_q.size(), 0);
    check("final buf_sel", int'(buf_sel), 0);
    check("final OE", int'(OE), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Scan controller for the 64x32 HUB75 LED matrix. It reads pixel data from a double-buffered frame buffer and shifts one column pair (top and bottom half) per shift clock. It latches each row and shows it using binary-code-modulated bit planes for multi-level brightness. It sits between the game/render logic, which writes the back buffer and requests swaps, and the matrix connector pins.

## Interface
Parameters:
- COLS, 64, columns shifted per row
- ROWS, 16, row addresses (each drives two physical rows)
- PLANES, 4, bits per colour channel (BCM planes)
- BASE_ON, 8, OE-enabled clocks for plane 0 (LSB)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  scan enable; sampled only in IDLE and at frame end
- rd_addr  out  1+log2(ROWS)+log2(COLS)  frame-buffer read address {buf_sel, row, col}
- rd_data  in  6*PLANES  pixel word {r0,g0,b0,r1,g1,b1}, each PLANES bits; valid 1 clk after rd_addr
- swap_req  in  1  level request to swap front/back buffer; held until swap_ack
- swap_ack  out  1  one-cycle pulse when the swap is applied
- buf_sel  out  1  current front buffer
- frame_start  out  1  one-cycle pulse on the first SHIFT cycle of each frame
- A, B, C, D  out  1 each  row address, {D,C,B,A}=row
- R0, G0, B0, R1, G1, B1  out  1 each  pixel bits for the top/bottom half
- SCLK  out  1  column shift clock
- OE  out  1  output enable, active-low (1 = blanked)
- LAT  out  1  latch strobe, active-high

## Operation
- States: IDLE, SHIFT, LATCH, SHOW.
- IDLE: OE=1, SCLK=0, LAT=0. Moves to SHIFT when en=1.
- SHIFT (per plane p, row r): rd_addr col=c is issued in cycle 2c. RGB outputs are registered from bit p of each rd_data channel at the end of cycle 2c+1. SCLK=1 during cycle 2c+3, otherwise 0. Lasts 2*COLS+2 cycles. OE=1 throughout.
- LATCH: one cycle with LAT=1 and OE=1. {D,C,B,A} updates to r at the start of LATCH and never changes while OE=0.
- SHOW: OE=0 for exactly BASE_ON<<p cycles, then OE=1.
  - If p<PLANES-1: p++ and return to SHIFT.
  - Otherwise p=0 and r++ (wraps ROWS-1 to 0).
  - At wrap (frame end): if swap_req=1, toggle buf_sel and pulse swap_ack. Then go to SHIFT if en=1, else IDLE.
- swap_req sampled high in the final SHOW cycle counts for this frame. buf_sel never changes mid-frame.
- Counters: col 0..COLS-1, plane 0..PLANES-1, row 0..ROWS-1, show counter wide enough for BASE_ON<<(PLANES-1); all wrap or reload without overflow.
- Reset values: A-D=0, RGB=0, SCLK=0, OE=1, LAT=0, swap_ack=0, frame_start=0, buf_sel=0, rd_addr=0. State returns to IDLE with all counters 0.
- Reset mid-frame aborts immediately; a pending swap is dropped and must be re-requested.

## Timing
- Cycles per plane: 2*COLS+3+(BASE_ON<<p).
- With defaults: 644 clocks per row and 10304 clocks per frame. No idle cycles between rows while en=1.
- rd_data latency is fixed at 1 clock; no stall support.
- swap_ack is asserted in the cycle after the last SHOW cycle. It coincides with frame_start when en=1.
- LAT and OE=0 are never high/low in the same cycle. SCLK is never 1 outside SHIFT.

## Structure
- Shared package matrix_pkg:
  - state encoding (IDLE/SHIFT/LATCH/SHOW)
  - default COLS/ROWS/PLANES/BASE_ON
  - address width constant
  - rd_data channel field offsets
- One sub-module, matrix_show_timer:
  - loadable down-counter, loaded with BASE_ON<<plane
  - outputs a done pulse

## Test plan
- Reset then en=1 with a frame buffer holding all-ones: first SCLK rise at cycle 3 of SHIFT; 64 SCLK pulses; LAT at cycle 130; OE=0 for 8, 16, 32, 64 clocks on planes 0-3.
- Pixel word with only r0 bit2 set at col 5, row 3: R0=1 only on the 6th SCLK of plane 2, row 3; all other RGB 0.
- swap_req raised mid-frame: swap_ack exactly one pulse at frame end (cycle 10304 from frame_start), buf_sel toggles, rd_addr MSB follows from the next frame.
- en dropped mid-frame: the frame completes through row 15 plane 3, then IDLE with OE=1 and no further SCLK.
- Async rst asserted during SHOW of row 7: all outputs take reset values at once, OE=1, pending swap lost, scan restarts at row 0 plane 0.
- Continuous checker: {D,C,B,A} is stable whenever OE=0; LAT=1 only when OE=1; row sequence 0..15 wraps.
